// File: rtl/lcd_frame_fetch.sv
`default_nettype none
// ============================================================================
// Module   : lcd_frame_fetch
// Brief    : Streams a word range out of on-chip RAM as 16-bit pixels.
// Revision : 1.0
// ============================================================================
module lcd_frame_fetch #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int PIX_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready
);

    localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0]  c_DEPTH     = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   c_MAX_WORDS = (ADDR_W + 1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0]   c_ONE_WORD  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr, w_ptr_nxt;
    logic [ADDR_W:0]     r_rem, w_rem_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic [ADDR_W-1:0]   r_mem_address, w_mem_address_nxt;
    logic                r_mem_clken, w_mem_clken_nxt;

    logic                r_inflight;
    logic                r_half;
    logic [DATA_W-1:0]   r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]  r_fifo_count;

    logic [ADDR_W:0]     w_len;
    logic [c_CNT_W:0]    w_outstanding;
    logic                w_credit;
    logic                w_push, w_hs, w_pop, w_last;
    logic [DATA_W-1:0]   w_head;

    assign w_len = (word_count > c_MAX_WORDS) ? c_MAX_WORDS : word_count;

    // Buffered words plus reads issued but not yet captured must never exceed the FIFO.
    assign w_outstanding = {1'b0, r_fifo_count}
                         + (c_CNT_W + 1)'(r_inflight)
                         + (c_CNT_W + 1)'(r_mem_clken);
    assign w_credit      = (w_outstanding < c_DEPTH);

    assign w_push = r_inflight;
    assign w_hs   = pix_valid & pix_ready;
    assign w_pop  = w_hs & r_half;
    assign w_last = !r_mem_clken && !r_inflight &&
                    ((r_fifo_count == c_CNT_W'(1) && w_pop) || (r_fifo_count == '0));

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_rem_nxt         = r_rem;
        w_busy_nxt        = r_busy;
        w_done_nxt        = 1'b0;
        w_mem_address_nxt = r_mem_address;
        w_mem_clken_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        // The first read is issued straight from the start cycle.
                        w_mem_address_nxt = base_addr;
                        w_mem_clken_nxt   = 1'b1;
                        w_ptr_nxt         = base_addr + ADDR_W'(1);
                        w_rem_nxt         = w_len - c_ONE_WORD;
                        w_busy_nxt        = 1'b1;
                        w_state_nxt       = (w_len == c_ONE_WORD) ? S_DRAIN : S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (w_credit) begin
                    w_mem_address_nxt = r_ptr;
                    w_mem_clken_nxt   = 1'b1;
                    w_ptr_nxt         = r_ptr + ADDR_W'(1);
                    w_rem_nxt         = r_rem - c_ONE_WORD;
                    if (r_rem == c_ONE_WORD) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_last) begin
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_rem         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_address <= '0;
            r_mem_clken   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_rem         <= w_rem_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_mem_address <= w_mem_address_nxt;
            r_mem_clken   <= w_mem_clken_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_inflight   <= 1'b0;
            r_half       <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            r_inflight <= r_mem_clken;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_hs) begin
                r_half <= ~r_half;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + c_CNT_W'(1);
                2'b01:   r_fifo_count <= r_fifo_count - c_CNT_W'(1);
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= mem_readdata;
        end
    end

    assign w_head    = r_fifo[r_rd_ptr];
    assign pix_valid = (r_fifo_count != '0);
    assign pix_data  = !pix_valid ? '0 :
                       (r_half ? w_head[DATA_W-1:PIX_W] : w_head[PIX_W-1:0]);

    assign busy        = r_busy;
    assign done        = r_done;
    assign mem_address = r_mem_address;
    assign mem_clken   = r_mem_clken;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_fetch.sv
`default_nettype none
// Bench for lcd_frame_fetch: RAM model, word-range expectation queues and a
// per-cycle compare process, plus literal pins for the directed scenarios.
module tb_lcd_frame_fetch;
    localparam int ADDR_W = 10, DATA_W = 32, PIX_W = 16, FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_count = '0;
    logic              busy, done, mem_clken, pix_valid;
    logic              pix_ready = 1'b0;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_readdata;
    logic [PIX_W-1:0]  pix_data;

    logic [DATA_W-1:0] mem [0:1023];

    lcd_frame_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIX_W(PIX_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .mem_address(mem_address),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata), .pix_data(pix_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready)
    );

    always #5 clk = ~clk;

    // Synchronous RAM read port.
    always @(posedge clk) if (mem_clken) mem_readdata <= mem[mem_address];

    int errors = 0, checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [PIX_W-1:0]  exp_pix[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [PIX_W-1:0]  obs_pix[$];
    logic [ADDR_W-1:0] obs_addr[$];
    int n_clken = 0, n_pix = 0, n_done = 0, words_expected = 0;
    int n_issued = 0, n_hs = 0, hs_cyc = -10;
    bit prev_stall = 0;
    logic [PIX_W-1:0] prev_data = '0;
    bit rdy_random = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the expectation queues.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_pix.delete();
            exp_addr.delete();
            prev_stall = 0;
            n_issued = 0;
            n_hs = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", 32'(pix_valid), 32'd1);
                check("stall_data_held", 32'(pix_data), 32'(prev_data));
            end
            if (mem_clken) begin
                n_clken++;
                n_issued++;
                obs_addr.push_back(mem_address);
                if (exp_addr.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: address %0h, no read expected", mem_address);
                end else begin
                    check("mem_address", 32'(mem_address), 32'(exp_addr.pop_front()));
                end
            end
            check("outstanding_le_depth", 32'((n_issued - n_hs / 2) <= FIFO_DEPTH), 32'd1);
            if (pix_valid && pix_ready) begin
                n_pix++;
                n_hs++;
                hs_cyc = cyc;
                obs_pix.push_back(pix_data);
                if (exp_pix.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pixel: data %0h, no pixel expected", pix_data);
                end else begin
                    check("pix_data", 32'(pix_data), 32'(exp_pix.pop_front()));
                end
            end
            if (done) begin
                n_done++;
                check("busy_low_at_done", 32'(busy), 32'd0);
                check("no_pixels_left_at_done", 32'(exp_pix.size()), 32'd0);
                if (words_expected > 0)
                    check("done_after_last_hs", 32'(hs_cyc), 32'(cyc - 1));
            end
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            pix_ready = rdy_random ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_xfer(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] wc);
        int n;
        logic [ADDR_W-1:0] a;
        n = (wc > 11'd1024) ? 1024 : int'(wc);
        for (int i = 0; i < n; i++) begin
            a = b + ADDR_W'(i);
            exp_addr.push_back(a);
            exp_pix.push_back(mem[a][15:0]);
            exp_pix.push_back(mem[a][31:16]);
        end
        words_expected = n;
        n_clken = 0; n_pix = 0; n_done = 0;
        obs_pix.delete(); obs_addr.delete();
        @(posedge clk); #1;
        base_addr = b; word_count = wc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (done) begin got = 1; break; end
        end
        check("done_within_budget", 32'(got), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
        check({tag, "_mem_clken"}, 32'(mem_clken), 32'd0);
        check({tag, "_mem_address"}, 32'(mem_address), 32'd0);
    endtask

    logic [PIX_W-1:0]  lit_pix [8] = '{16'h1111, 16'hAAAA, 16'h2222, 16'hBBBB,
                                        16'h3333, 16'hCCCC, 16'h4444, 16'hDDDD};
    logic [ADDR_W-1:0] lit_addr [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[10'h010] = 32'hAAAA1111; mem[10'h011] = 32'hBBBB2222;
        mem[10'h012] = 32'hCCCC3333; mem[10'h013] = 32'hDDDD4444;
        mem[10'h3FE] = 32'h0F0F3FE0; mem[10'h3FF] = 32'h0F0F3FF0;
        mem[10'h000] = 32'h5A5AC3C3; mem[10'h001] = 32'h0F0F0010;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Basic transfer with the sink always ready.
        rdy_random = 0;
        start_xfer(10'h010, 11'd4);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        check("t1_addr_after_start", 32'(mem_address), 32'h010);
        check("t1_clken_after_start", 32'(mem_clken), 32'd1);
        check("t1_valid_edge_n", 32'(pix_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_valid_edge_n1", 32'(pix_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_valid_edge_n2", 32'(pix_valid), 32'd1);
        check("t1_first_pixel", 32'(pix_data), 32'h1111);
        wait_done(100);
        check("t1_clken_cycles", 32'(n_clken), 32'd4);
        check("t1_pixels", 32'(n_pix), 32'd8);
        check("t1_done_pulses", 32'(n_done), 32'd1);
        check("t1_pix_log_size", 32'(obs_pix.size()), 32'd8);
        if (obs_pix.size() == 8)
            for (int i = 0; i < 8; i++) check("t1_pix_literal", 32'(obs_pix[i]), 32'(lit_pix[i]));

        // Same transfer under random backpressure; a second start mid-transfer must be ignored.
        rdy_random = 1;
        start_xfer(10'h010, 11'd4);
        repeat (3) @(posedge clk);
        #1;
        base_addr = 10'h3FE; word_count = 11'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(400);
        check("t2_clken_cycles", 32'(n_clken), 32'd4);
        check("t2_pixels", 32'(n_pix), 32'd8);
        check("t2_done_pulses", 32'(n_done), 32'd1);
        if (obs_pix.size() == 8)
            for (int i = 0; i < 8; i++) check("t2_pix_literal", 32'(obs_pix[i]), 32'(lit_pix[i]));
        rdy_random = 0;

        // Address wrap at the top of memory.
        start_xfer(10'h3FE, 11'd4);
        wait_done(100);
        check("t3_addr_log_size", 32'(obs_addr.size()), 32'd4);
        if (obs_addr.size() == 4)
            for (int i = 0; i < 4; i++) check("t3_addr_literal", 32'(obs_addr[i]), 32'(lit_addr[i]));
        check("t3_pixels", 32'(n_pix), 32'd8);

        // Zero-length request.
        start_xfer(10'h055, 11'd0);
        check("t4_done_after_start", 32'(done), 32'd1);
        check("t4_busy_after_start", 32'(busy), 32'd0);
        check("t4_clken_after_start", 32'(mem_clken), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("t4_done_low", 32'(done), 32'd0);
            check("t4_busy_low", 32'(busy), 32'd0);
            check("t4_valid_low", 32'(pix_valid), 32'd0);
        end
        check("t4_done_pulses", 32'(n_done), 32'd1);
        check("t4_clken_cycles", 32'(n_clken), 32'd0);

        // Reset after the third pixel, then a one-word transfer.
        start_xfer(10'h010, 11'd4);
        for (int k = 0; k < 50 && n_pix < 3; k++) begin
            @(posedge clk); #1;
        end
        check("t5_reached_three_pixels", 32'(n_pix), 32'd3);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check_reset_outputs("t5_reset");
        start_xfer(10'h000, 11'd1);
        wait_done(100);
        check("t5_pixels", 32'(n_pix), 32'd2);
        check("t5_done_pulses", 32'(n_done), 32'd1);
        if (obs_pix.size() == 2) begin
            check("t5_pix0", 32'(obs_pix[0]), 32'hC3C3);
            check("t5_pix1", 32'(obs_pix[1]), 32'h5A5A);
        end

        // Oversized request clamps to a full memory sweep.
        for (int i = 0; i < 1024; i++) mem[i] = 32'($urandom);
        start_xfer(10'h200, 11'd2000);
        wait_done(3000);
        check("t6_clken_cycles", 32'(n_clken), 32'd1024);
        check("t6_pixels", 32'(n_pix), 32'd2048);
        check("t6_done_pulses", 32'(n_done), 32'd1);
        if (obs_addr.size() == 1024) begin
            check("t6_first_addr", 32'(obs_addr[0]), 32'h200);
            check("t6_wrap_addr", 32'(obs_addr[512]), 32'h000);
            check("t6_last_addr", 32'(obs_addr[1023]), 32'h1FF);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
